// File: rtl/gouram_mp_pkg.sv
// Shared types and record-layout helpers for the gouram_mp trace monitor.
// A record is packed MSB to LSB as:
//   kind[1:0] | port[2:0] | jump | payload | ts_start | ts_end
package gouram_datatypes;

  typedef enum logic [1:0] {
    KIND_NONE = 2'b00,
    KIND_IF   = 2'b01,
    KIND_MEM  = 2'b10
  } rec_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_WAIT_GNT = 2'b01,
    ST_WAIT_RV  = 2'b10
  } port_state_e;

  localparam int KIND_W = 2;
  localparam int PORT_W = 3;
  localparam int JUMP_W = 1;

  // ts_end always sits at the bottom of the record
  localparam int OFF_TS_END = 0;

  function automatic int PAYLOAD_W(input int iw, input int aw);
    return (iw > aw) ? iw : aw;
  endfunction

  function automatic int OFF_TS_START(input int tw);
    return tw;
  endfunction

  function automatic int OFF_PAYLOAD(input int tw);
    return 2 * tw;
  endfunction

  function automatic int OFF_JUMP(input int iw, input int aw, input int tw);
    return OFF_PAYLOAD(tw) + PAYLOAD_W(iw, aw);
  endfunction

  function automatic int OFF_PORT(input int iw, input int aw, input int tw);
    return OFF_JUMP(iw, aw, tw) + JUMP_W;
  endfunction

  function automatic int OFF_KIND(input int iw, input int aw, input int tw);
    return OFF_PORT(iw, aw, tw) + PORT_W;
  endfunction

  function automatic int REC_W(input int iw, input int aw, input int tw);
    return OFF_KIND(iw, aw, tw) + KIND_W;
  endfunction

endpackage

// File: rtl/gouram_trace_fifo.sv
// Trace record FIFO. Head is presented combinationally on rd_data (zero when
// empty). A write is accepted while full if a read happens in the same cycle.
module gouram_trace_fifo
  import gouram_datatypes::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_wr;
  logic             w_do_rd;

  assign full    = (r_count == (AW+1)'(DEPTH));
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign w_do_rd = rd_en & ~empty;
  assign w_do_wr = wr_en & (~full | w_do_rd);
  assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

  // storage array, not reset: contents are only visible through rd_ptr
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= wr_data;
  end

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_do_wr) - (AW+1)'(w_do_rd);
    end
  end

endmodule

// File: rtl/gouram_mp.sv
// gouram_mp: processor fetch / data-port trace monitor.
// Each source (IF plus one per data port) owns a one-entry holding register;
// a fixed-priority arbiter (IF first, then port 0 upward) moves one record per
// cycle into the trace FIFO. Events hitting an occupied holding register are
// dropped and flagged.
// Build option: GOURAM_DROP_COUNTER_EN enables the saturating drop_count;
// without it drop_count reads 0 and only the sticky overflow flag is kept.
// Note: rst_n is active-high and asynchronous in this codebase.
//
// Per-port data FSM:
//   state       | meaning
//   ST_IDLE     | no transaction outstanding
//   ST_WAIT_GNT | request seen, address/ts_start stored, waiting for grant
//   ST_WAIT_RV  | granted, waiting for read/write response
module gouram_mp
  import gouram_datatypes::*;
#(
  parameter int INSTR_DATA_WIDTH = 32,
  parameter int DATA_ADDR_WIDTH  = 32,
  parameter int NUM_DATA_PORTS   = 2,
  parameter int FIFO_DEPTH       = 16,
  parameter int TS_WIDTH         = 32,
  localparam int REC_WIDTH = REC_W(INSTR_DATA_WIDTH, DATA_ADDR_WIDTH, TS_WIDTH)
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      jump_done,
  input  logic                                      instr_rvalid,
  input  logic [INSTR_DATA_WIDTH-1:0]               instr_rdata,
  input  logic [NUM_DATA_PORTS-1:0]                 data_req,
  input  logic [NUM_DATA_PORTS-1:0]                 data_gnt,
  input  logic [NUM_DATA_PORTS-1:0]                 data_rvalid,
  input  logic [NUM_DATA_PORTS*DATA_ADDR_WIDTH-1:0] data_addr,
  output logic                                      trace_valid,
  input  logic                                      trace_ready,
  output logic [REC_WIDTH-1:0]                      trace_data,
  output logic                                      overflow,
  output logic [15:0]                               drop_count
);

  localparam int NS = NUM_DATA_PORTS + 1;
  localparam int PW = PAYLOAD_W(INSTR_DATA_WIDTH, DATA_ADDR_WIDTH);

  logic [TS_WIDTH-1:0]        r_ts;
  logic                       r_jump_pend;
  logic                       r_overflow;
  port_state_e                r_state     [NUM_DATA_PORTS];
  port_state_e                w_state_nxt [NUM_DATA_PORTS];
  logic [DATA_ADDR_WIDTH-1:0] r_addr      [NUM_DATA_PORTS];
  logic [TS_WIDTH-1:0]        r_ts_start  [NUM_DATA_PORTS];
  logic [NUM_DATA_PORTS-1:0]  w_start;

  logic [NS-1:0]              r_hold_vld;
  logic [REC_WIDTH-1:0]       r_hold_rec [NS];
  logic [NS-1:0]              w_new_vld;
  logic [REC_WIDTH-1:0]       w_new_rec  [NS];
  logic [NS-1:0]              w_grant;
  logic [NS-1:0]              w_free;
  logic [NS-1:0]              w_drop;

  logic                       w_fifo_full;
  logic                       w_fifo_empty;
  logic                       w_fifo_wr;
  logic                       w_fifo_rd;
  logic                       w_fifo_can_wr;
  logic [REC_WIDTH-1:0]       w_fifo_din;
  logic [$clog2(FIFO_DEPTH):0] w_fifo_count;
  logic                       w_unused_count;

  assign w_unused_count = ^w_fifo_count;

  // free-running timestamp, wraps naturally
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) r_ts <= '0;
    else       r_ts <= r_ts + TS_WIDTH'(1);
  end

  // new events per source and data-port FSM next state
  always_comb begin
    w_new_vld = '0;
    for (int s = 0; s < NS; s++) w_new_rec[s] = '0;
    w_new_vld[0] = instr_rvalid;
    w_new_rec[0] = {KIND_IF, PORT_W'(0), r_jump_pend | jump_done,
                    PW'(instr_rdata), r_ts, r_ts};
    for (int i = 0; i < NUM_DATA_PORTS; i++) begin
      w_state_nxt[i] = r_state[i];
      w_start[i]     = 1'b0;
      w_new_rec[i+1] = {KIND_MEM, PORT_W'(i), 1'b0,
                        PW'(r_addr[i]), r_ts_start[i], r_ts};
      case (r_state[i])
        ST_IDLE:     w_start[i] = data_req[i];
        ST_WAIT_GNT: if (data_gnt[i]) w_state_nxt[i] = ST_WAIT_RV;
        ST_WAIT_RV: begin
          if (data_rvalid[i]) begin
            w_new_vld[i+1] = 1'b1;
            w_start[i]     = data_req[i];
            w_state_nxt[i] = ST_IDLE;
          end
        end
        default:     w_state_nxt[i] = ST_IDLE;
      endcase
      // a new request (from idle or right behind a response) skips WAIT_GNT if granted now
      if (w_start[i]) w_state_nxt[i] = data_gnt[i] ? ST_WAIT_RV : ST_WAIT_GNT;
    end
  end

  // data-port FSM state, captured address and start timestamp
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < NUM_DATA_PORTS; i++) begin
        r_state[i]    <= ST_IDLE;
        r_addr[i]     <= '0;
        r_ts_start[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_DATA_PORTS; i++) begin
        r_state[i] <= w_state_nxt[i];
        if (w_start[i]) begin
          r_addr[i]     <= data_addr[i*DATA_ADDR_WIDTH +: DATA_ADDR_WIDTH];
          r_ts_start[i] <= r_ts;
        end
      end
    end
  end

  // fixed-priority arbitration into the FIFO; lowest source index wins
  always_comb begin
    w_grant    = '0;
    w_fifo_din = '0;
    for (int s = NS - 1; s >= 0; s--) begin
      if (r_hold_vld[s] && w_fifo_can_wr) begin
        w_grant    = '0;
        w_grant[s] = 1'b1;
        w_fifo_din = r_hold_rec[s];
      end
    end
    w_free = ~r_hold_vld | w_grant;
    w_drop = w_new_vld & ~w_free;
  end

  assign w_fifo_rd     = trace_valid & trace_ready;
  assign w_fifo_can_wr = ~w_fifo_full | w_fifo_rd;
  assign w_fifo_wr     = |w_grant;
  assign trace_valid   = ~w_fifo_empty;

  // holding registers: a slot drained this cycle can take a new event at once
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_hold_vld <= '0;
      for (int s = 0; s < NS; s++) r_hold_rec[s] <= '0;
    end else begin
      for (int s = 0; s < NS; s++) begin
        if (w_new_vld[s] && w_free[s]) begin
          r_hold_vld[s] <= 1'b1;
          r_hold_rec[s] <= w_new_rec[s];
        end else if (w_grant[s]) begin
          r_hold_vld[s] <= 1'b0;
        end
      end
    end
  end

  // jump pending bit survives until an IF record actually carries it
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)                        r_jump_pend <= 1'b0;
    else if (instr_rvalid && w_free[0]) r_jump_pend <= 1'b0;
    else if (jump_done)               r_jump_pend <= 1'b1;
  end

  // sticky overflow on any dropped event
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)        r_overflow <= 1'b0;
    else if (|w_drop) r_overflow <= 1'b1;
  end

  assign overflow = r_overflow;

`ifdef GOURAM_DROP_COUNTER_EN
  logic [3:0]  w_drop_num;
  logic [16:0] w_drop_sum;
  logic [15:0] r_drop_count;

  // several sources may drop in the same cycle
  always_comb begin
    w_drop_num = '0;
    for (int s = 0; s < NS; s++) w_drop_num = w_drop_num + 4'(w_drop[s]);
    w_drop_sum = {1'b0, r_drop_count} + 17'(w_drop_num);
  end

  // saturating drop counter
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)              r_drop_count <= '0;
    else if (w_drop_sum[16]) r_drop_count <= 16'hFFFF;
    else                    r_drop_count <= w_drop_sum[15:0];
  end

  assign drop_count = r_drop_count;
`else
  assign drop_count = '0;
`endif

  gouram_trace_fifo #(
    .WIDTH (REC_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_fifo_wr),
    .wr_data (w_fifo_din),
    .full    (w_fifo_full),
    .rd_en   (w_fifo_rd),
    .rd_data (trace_data),
    .empty   (w_fifo_empty),
    .count   (w_fifo_count)
  );

endmodule

// File: doc/gouram_mp.md
GOURAM_MP -- requirements
Module: gouram_mp

Interface
REQ-001 SHALL have parameter INSTR_DATA_WIDTH, default 32, instruction word width.
REQ-002 SHALL have parameter DATA_ADDR_WIDTH, default 32, data address width.
REQ-003 SHALL have parameter NUM_DATA_PORTS, default 2, number of traced data memory ports (1..8).
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, trace FIFO entries (power of two, >=2).
REQ-005 SHALL have parameter TS_WIDTH, default 32, timestamp width.
REQ-006 SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-007 SHALL have port rst_n, input, 1, reset: asynchronous, active-high.
REQ-008 SHALL have port jump_done, input, 1, processor jump completed this cycle.
REQ-009 SHALL have ports instr_rvalid (input, 1) and instr_rdata (input, INSTR_DATA_WIDTH): fetch return.
REQ-010 SHALL have ports data_req, data_gnt and data_rvalid (input, NUM_DATA_PORTS each; one bit per port).
REQ-011 SHALL have port data_addr, input, NUM_DATA_PORTS*DATA_ADDR_WIDTH; port i occupies bits [i*DATA_ADDR_WIDTH +: DATA_ADDR_WIDTH].
REQ-012 SHALL have ports trace_valid (output, 1), trace_ready (input, 1) and trace_data (output, REC_W): trace record stream.
REQ-013 SHALL have port overflow, output, 1, sticky flag: at least one event dropped.
REQ-014 SHALL have port drop_count, output, 16, count of dropped events.

Function
REQ-015 SHALL keep a TS_WIDTH timestamp counter: reset value 0, +1 every cycle, wraps modulo 2^TS_WIDTH.
REQ-016 SHALL pack each record, MSB to LSB, as kind[1:0], port[2:0], jump[0], payload[max(INSTR_DATA_WIDTH,DATA_ADDR_WIDTH)-1:0], ts_start[TS_WIDTH-1:0], ts_end[TS_WIDTH-1:0].
REQ-017 SHALL capture an IF record (kind=IF, port=0, payload=instr_rdata, ts_start=ts_end=current ts) into the IF holding register on every cycle with instr_rvalid=1.
REQ-018 SHALL latch jump_done into a pending bit; the next IF record carries jump=1 and clears the bit. jump_done in the same cycle as instr_rvalid SHALL apply to that record.
REQ-019 SHALL run one FSM per data port with states IDLE, WAIT_GNT and WAIT_RV:
- IDLE, req=1: store addr and ts_start, then go to WAIT_RV if gnt=1, otherwise WAIT_GNT.
- WAIT_GNT, gnt=1: go to WAIT_RV.
- WAIT_RV, rvalid=1: emit a MEM record (kind=MEM, port=i, payload=addr, ts_end=current ts) to that port's holding register.
- WAIT_RV, rvalid=1 with req=1 in the same cycle: start the new transaction as in IDLE.
- WAIT_RV, rvalid=1 with req=0: return to IDLE.
REQ-020 SHALL NOT correct wrapped timestamps; ts_end<ts_start is legal.
REQ-021 SHALL have one holding register per source (IF plus each data port). Each cycle, a fixed-priority arbiter (IF highest, then port 0 upward) SHALL write one occupied holding register into the FIFO if the FIFO is not full.
REQ-022 SHALL let a holding register that is written to the FIFO accept a new event in the same cycle.
REQ-023 SHALL drop a new event arriving while its source holding register stays occupied. A dropped event SHALL set overflow and increment drop_count, saturating at 0xFFFF.
REQ-024 SHALL present records on trace_valid/trace_data from FIFO head. A record transfers when trace_valid&&trace_ready. trace_data SHALL be stable while trace_valid=1 and trace_ready=0.
REQ-025 SHALL have a latency, with FIFO empty and no contention, of: event cycle N, holding register cycle N+1, FIFO write at edge N+1, trace_valid=1 in cycle N+2.
REQ-026 SHALL allow a FIFO write and read in the same cycle when the FIFO is full; occupancy stays unchanged and no drop occurs.

Reset
REQ-027 SHALL, while rst_n=1, immediately clear: timestamp, FSMs (to IDLE), holding registers, jump pending bit, FIFO pointers, trace_valid, overflow and drop_count. trace_data SHALL be 0.
REQ-028 SHALL discard in-flight transactions when reset is asserted mid-operation; no partial records are emitted.

Configuration
REQ-029 SHALL, with GOURAM_DROP_COUNTER_EN defined, implement drop_count as in REQ-023. Without it, drop_count SHALL be tied to 0 while overflow remains functional.

Structure
REQ-030 SHALL place in package gouram_datatypes: the record-kind enum (IF=2'b01, MEM=2'b10), the field-offset constants, and a REC_W function of the parameters.
REQ-031 SHALL implement the FIFO as sub-module gouram_trace_fifo (parameters WIDTH, DEPTH; wr_en, full, rd_en, empty, count).

Verification
REQ-032 Single fetch: instr_rvalid=1, rdata=0x00000013 at ts=5 -> one IF record, payload 0x13, ts_start=ts_end=5, trace_valid 2 cycles later.
REQ-033 Data port 1: req at ts=10, gnt at ts=12, rvalid at ts=15, addr=0x1000 -> MEM record port=1, payload 0x1000, ts 10/15.
REQ-034 Back-to-back: port 0 rvalid and new req+gnt in the same cycle -> two MEM records, the second ts_start equal to the first ts_end.
REQ-035 Contention: IF and ports 0 and 1 complete in the same cycle -> FIFO order IF, P0, P1 on consecutive writes.
REQ-036 Backpressure: trace_ready=0 with 20 fetches and FIFO_DEPTH=16 -> 17 records retained (16 FIFO + 1 holding), overflow=1, drop_count=3 (macro on) or 0 (macro off).
REQ-037 Reset during WAIT_RV -> no record emitted; trace_valid=0; timestamp restarts at 0.
